// File: rtl/sender_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sender_arbiter
// Purpose  : Round-robin controller that shares one 7-bit serial frame sender
//            among N_REQ requesters. It latches the winner's data, pulses the
//            sender start for one cycle and waits for the sender's
//            completion flag. Grant and completion go back to the winner.
// Ports    : clk, rstN (async, active-low)
//            req[N_REQ], req_data[7*N_REQ]   - requester side inputs
//            gnt[N_REQ], done[N_REQ]         - one-hot 1-cycle pulses
//            busy, active_id[ID_W], err      - status
//            tx_start, tx_data[7], tx_sent   - sender side
// Options  : SENDER_ARB_TIMEOUT_EN - adds a WAIT-state watchdog that aborts a
//            transfer after TIMEOUT_CYCLES cycles and pulses err.
// Revision : 1.0 - initial release
// ============================================================================
module sender_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ID_W           = $clog2(N_REQ),
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [ID_W-1:0]    active_id,
    output logic               err,
    output logic               tx_start,
    output logic [6:0]         tx_data,
    input  logic               tx_sent
);

    // Elaboration-time sanity checks on the configuration.
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("sender_arbiter: N_REQ must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sender_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic              r_sent_q;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]  r_done, w_done_nxt;
    logic              r_busy, w_busy_nxt;
    logic [ID_W-1:0]   r_active_id, w_active_id_nxt;
    logic              r_tx_start, w_tx_start_nxt;
    logic [6:0]        r_tx_data, w_tx_data_nxt;

    // Requester data unpacked into one 7-bit word per requester.
    logic [6:0]        w_data [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_data[gi] = req_data[7*gi +: 7];
    end

    // Round-robin scan starting at r_rr_ptr; first requester found wins.
    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic [ID_W-1:0]   w_scan;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && req[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan;
            end
        end
    end

    // A completion is a rising edge of the sender's level flag. A flag left
    // high by the previous frame is masked because r_sent_q is already 1.
    logic w_complete;
    assign w_complete = (r_state == S_WAIT) && tx_sent && !r_sent_q;

    // Pointer value after serving active_id, wrapping N_REQ-1 -> 0.
    logic [ID_W-1:0] w_rr_after;
    assign w_rr_after = (r_active_id == ID_W'(N_REQ - 1)) ? '0
                                                          : r_active_id + 1'b1;

`ifdef SENDER_ARB_TIMEOUT_EN
    localparam logic [15:0] c_WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdog, w_wdog_nxt;
    logic        r_err, w_err_nxt;
    logic        w_timeout;

    // r_wdog holds the number of WAIT edges seen so far; the edge that would
    // make it reach TIMEOUT_CYCLES performs the abort.
    assign w_timeout = (r_state == S_WAIT) && (r_wdog == c_WDOG_LAST);
    assign err       = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_gnt_nxt       = '0;
        w_done_nxt      = '0;
        w_busy_nxt      = r_busy;
        w_active_id_nxt = r_active_id;
        w_tx_start_nxt  = 1'b0;
        w_tx_data_nxt   = r_tx_data;
`ifdef SENDER_ARB_TIMEOUT_EN
        w_wdog_nxt      = '0;
        w_err_nxt       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_tx_data_nxt       = w_data[w_winner];
                    w_tx_start_nxt      = 1'b1;
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_active_id_nxt     = w_winner;
                    w_busy_nxt          = 1'b1;
                    w_state_nxt         = S_WAIT;
                end
            end
            S_WAIT: begin
`ifdef SENDER_ARB_TIMEOUT_EN
                w_wdog_nxt = r_wdog + 16'd1;
`endif
                if (w_complete) begin
                    w_done_nxt[r_active_id] = 1'b1;
                    w_busy_nxt              = 1'b0;
                    w_rr_ptr_nxt            = w_rr_after;
                    w_state_nxt             = S_IDLE;
                end
`ifdef SENDER_ARB_TIMEOUT_EN
                // Completion takes precedence over a simultaneous timeout.
                else if (w_timeout) begin
                    w_err_nxt    = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_rr_ptr_nxt = w_rr_after;
                    w_state_nxt  = S_IDLE;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_sent_q    <= 1'b0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_active_id <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
`ifdef SENDER_ARB_TIMEOUT_EN
            r_wdog      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_sent_q    <= tx_sent;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_active_id <= w_active_id_nxt;
            r_tx_start  <= w_tx_start_nxt;
            r_tx_data   <= w_tx_data_nxt;
`ifdef SENDER_ARB_TIMEOUT_EN
            r_wdog      <= w_wdog_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = r_busy;
    assign active_id = r_active_id;
    assign tx_start  = r_tx_start;
    assign tx_data   = r_tx_data;

endmodule
`default_nettype wire

// File: doc/sender_arbiter.md
Name: sender_arbiter

Overview:
- Round-robin controller that shares one 7-bit serial frame sender among N_REQ requesters.
- Latches the winning requester's data, issues a single-cycle start pulse to the sender and waits for the sender's completion flag.
- Reports grant and completion back to the winning requester.
- Sits between the client logic and the sender. The sender's start, data_in and sent connect directly to tx_start, tx_data and tx_sent.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(N_REQ), width of active_id; derived, do not override.
- TIMEOUT_CYCLES, 32, watchdog limit in clk cycles. Used only with SENDER_ARB_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level; held high until the matching gnt bit pulses.
- req_data  in  7*N_REQ  requester i's data on bits [7i+6:7i]; must be stable while req[i]=1.
- gnt  out  N_REQ  one-hot, 1-cycle pulse: data of requester i captured.
- done  out  N_REQ  one-hot, 1-cycle pulse: requester i's frame fully sent.
- busy  out  1  high from the grant edge until the done (or err) edge.
- active_id  out  ID_W  index of the current or last granted requester.
- err  out  1  1-cycle pulse on watchdog abort; constant 0 without the macro.
- tx_start  out  1  to sender start; 1-cycle pulse.
- tx_data  out  7  to sender data_in; held stable from the grant until the next grant.
- tx_sent  in  1  from sender sent. Level signal: cleared by the sender when it accepts a start, set after the stop bit.

Behaviour:
- Reset (rstN=0, asynchronous) forces:
  - state=IDLE, rr_ptr=0, sent_q=0;
  - gnt, done, busy, err, tx_start all 0;
  - tx_data=0, active_id=0.
- Reset mid-frame abandons the transfer with no done and no err. The sender shares rstN.
- All outputs are registered.
- States are IDLE and WAIT.
- IDLE, when |req=1, at the clock edge:
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - tx_data <= req_data[winner]; tx_start <= 1; gnt[winner] <= 1.
  - active_id <= winner; busy <= 1; state <= WAIT.
- IDLE, when |req=0: outputs idle, state unchanged.
- WAIT:
  - tx_start and gnt return to 0 on the first WAIT edge.
  - sent_q registers tx_sent every cycle.
  - Completion = tx_sent=1 and sent_q=0 (rising edge). A tx_sent still high from the previous frame during the first WAIT cycle is not a completion, because sent_q=1.
  - On completion: done[active_id] <= 1; busy <= 0; rr_ptr <= (active_id+1) mod N_REQ; state <= IDLE.
- done and err are 1-cycle pulses.
- Latency and gaps:
  - gnt and tx_start appear 1 cycle after req is sampled in IDLE.
  - done appears 1 cycle after the controller samples the tx_sent rise.
  - Minimum gap between consecutive tx_start pulses = frame length + 3 cycles. A new grant may be issued on the edge right after done.
- Requests:
  - req changes during WAIT are ignored until IDLE.
  - A requester dropping req before its grant is never granted.
  - A requester may re-assert req in the cycle after its gnt; round-robin prevents it from starving others.
- Simultaneous requests are resolved only by rr_ptr; there is no fixed priority.
- rr_ptr advances only on completion, or on abort with the macro; wrap-around is N_REQ-1 -> 0.

Optional Feature:
- Macro: SENDER_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit wdog counter clears on WAIT entry and increments each WAIT cycle.
  - If wdog reaches TIMEOUT_CYCLES without a completion: err <= 1 (1 cycle), busy <= 0, rr_ptr <= active_id+1, state <= IDLE. No done is issued.
  - Completion and timeout in the same cycle: completion wins and err=0.
- When not defined: no counter is built, err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single request, with the real sender model: reset, then req=4'b0100, req_data[20:14]=7'h55.
  - Expect gnt=4'b0100 and tx_start=1 for exactly 1 cycle with tx_data=7'h55.
  - busy=1 until done=4'b0100 pulses 1 cycle after sent rises; active_id=2.
- All requesters, req=4'b1111 held, each with distinct data.
  - Expect grant order 0,1,2,3,0.
  - Each tx_data matches its source; never two tx_start pulses within one frame.
- Fairness with req0 and req3 both continuously high: grants alternate 0,3,0,3, and rr_ptr wraps 3->0.
- Late request: req1 asserted while WAIT serves id0.
  - Not granted until after done[0].
  - Granted on the edge after done[0]; no lost or duplicate gnt.
- Reset mid-frame: rstN low for 2 cycles during WAIT.
  - All outputs 0 immediately; no done or err afterwards.
  - The next request is granted normally from rr_ptr=0.
- With SENDER_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=32, and a stub that never raises tx_sent: err pulses exactly 32 WAIT cycles after the grant, done stays 0, busy falls, and the next requester is granted.
